ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port RAM command interface between two requesters.
- Each requester issues a complete word write or read using plain addr/data/we signals.
- The arbiter grants requesters round-robin and sequences the two-beat 10-bit RAM command protocol.
- For reads, it captures the RAM response and returns it with a one-cycle done pulse.
- Sits between the SPI-side/host logic and the RAM.

Parameters:
ADDR_SIZE, 8, width of requester address, write data and read data; ram_din width is ADDR_SIZE+2.
TIMEOUT_CYCLES, 15, read-response wait limit in cycles (used only with the optional feature).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  2  per-requester request level, bit i = requester i
req_we  input  2  1 = write, 0 = read, per requester
req_addr  input  2*ADDR_SIZE  requester i at [i*ADDR_SIZE +: ADDR_SIZE]
req_wdata  input  2*ADDR_SIZE  write data, same packing
done  output  2  one-cycle completion pulse, one-hot
rdata  output  ADDR_SIZE  read data, valid while a done bit of a read is high
rsp_err  output  1  read timeout flag, qualified by done
busy  output  1  high whenever state != IDLE
ram_din  output  ADDR_SIZE+2  command to RAM: {opcode[1:0], payload}
ram_rx_valid  output  1  command strobe to RAM
ram_dout  input  ADDR_SIZE  RAM read data
ram_tx_valid  input  1  RAM read-data valid

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are driven from flops only; there is no combinational path from req* to any output.
- Reset values: state = IDLE; done = 0; rdata = 0; rsp_err = 0; busy = 0; ram_rx_valid = 0; ram_din = 0; round-robin pointer favours requester 0.
- RAM opcodes:
  - 00: write address
  - 01: write data
  - 10: read address
  - 11: read data
- RAM behaviour the arbiter relies on: a command is accepted on any edge with ram_rx_valid = 1. After an opcode 11 command, ram_dout/ram_tx_valid are valid in the following cycle. Every other opcode clears ram_tx_valid.
- FSM states: IDLE, CMD_ADDR, CMD_DATA, RD_WAIT, DONE.
- IDLE:
  - If any req bit is high, arbitrate, latch the winner's index, we, addr and wdata, then go to CMD_ADDR.
  - Arbitration: a single requester wins outright. If both request, the winner is the one not granted last. The pointer updates on grant only.
- CMD_ADDR: ram_rx_valid = 1; ram_din = {we ? 00 : 10, addr}. Next state is CMD_DATA.
- CMD_DATA: ram_rx_valid = 1; ram_din = {we ? 01 : 11, we ? wdata : 0}. Next state is DONE for a write, RD_WAIT for a read.
- RD_WAIT: ram_rx_valid = 0.
  - If ram_tx_valid = 1, capture ram_dout into rdata and go to DONE.
  - Otherwise stay in RD_WAIT.
- DONE: done[idx] = 1 for exactly this cycle; next state is IDLE. req is not sampled in this cycle.
- ram_rx_valid is 0 in IDLE, RD_WAIT and DONE.
- Latency, with the grant in IDLE at cycle N:
  - write: done at N+3
  - read: done at N+4, rdata valid in that cycle
- Requester rules:
  - Hold req, we, addr and wdata until done is seen.
  - Drop req on the edge that ends the done cycle, otherwise a new transaction starts in the following IDLE.
  - Input changes after the latch in IDLE have no effect on the in-flight transaction.
- rdata holds its last captured value until the next read capture.
- Reset mid-transaction: immediate return to IDLE, no further RAM command is issued, and no done pulse is generated for the aborted transaction.

Optional Feature:
RAM_ARB_RD_TIMEOUT_EN
- Defined:
  - A counter runs in RD_WAIT.
  - After TIMEOUT_CYCLES cycles without ram_tx_valid, go to DONE with rsp_err = 1 and rdata unchanged.
  - rsp_err is cleared on the next done.
- Undefined: RD_WAIT waits indefinitely; rsp_err is tied 0 and there is no counter logic.

Decomposition:
- Package ram_ctrl_pkg:
  - opcode constants OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA
  - FSM state encoding
  - default ADDR_SIZE constant
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], update strobe.
  - Outputs: one-hot grant, winner index, internal last-grant pointer.

Test Plan:
- Reset, then requester 0 writes addr 0x12 data 0xA5 -> ram_din 0x012 then 0x1A5 on consecutive cycles, done[0] at N+3.
- Requester 1 reads addr 0x12 after the above -> ram_din 0x212 then 0x300; done[1] at N+4 with rdata = 0xA5 and rsp_err = 0.
- Both requesters hold req continuously, requester 0 writing and requester 1 reading -> grants alternate 0,1,0,1, no back-to-back grant to the same requester, and the first grant goes to requester 0.
- Assert rst while in CMD_DATA of a write -> state IDLE next cycle, ram_rx_valid 0, no done; a subsequent read of that address returns the old value.
- Requester 0 changes req_addr after the latch, mid-transaction -> the RAM still sees the latched address.
- With RAM_ARB_RD_TIMEOUT_EN, model ram_tx_valid stuck at 0 -> done pulse after 15 RD_WAIT cycles with rsp_err = 1 and rdata unchanged.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the RAM port arbiter: the two-bit RAM command
// opcodes, the arbiter FSM state encoding, the default word width and small
// helpers for building command words and completion pulses.
// No ports (package).
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

  // Default width of requester address, write data and read data.
  localparam int ADDR_SIZE_DEF = 8;

  // RAM command opcodes, carried in the top two bits of ram_din.
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD_ADDR = 3'd1,
    ST_CMD_DATA = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Opcode for the first (address) beat of a transaction.
  function automatic logic [1:0] addr_opcode(input logic we);
    return we ? OP_WR_ADDR : OP_RD_ADDR;
  endfunction

  // Opcode for the second (data) beat of a transaction.
  function automatic logic [1:0] data_opcode(input logic we);
    return we ? OP_WR_DATA : OP_RD_DATA;
  endfunction

  // One-hot vector for a two-requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
// Requester-side bus of the RAM port arbiter. Both requesters share one
// instance; per-requester fields are packed with requester i at bit i (1-bit
// fields) or at [i*ADDR_SIZE +: ADDR_SIZE] (word fields).
//   req       : request level per requester
//   req_we    : 1 = write, 0 = read, per requester
//   req_addr  : word address per requester
//   req_wdata : write data per requester
//   done      : one-cycle, one-hot completion pulse
//   rdata     : read data, meaningful while a read's done bit is high
//   rsp_err   : read timeout flag, qualified by done
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
  parameter int ADDR_SIZE = ram_ctrl_pkg::ADDR_SIZE_DEF
);

  logic [1:0]             req;
  logic [1:0]             req_we;
  logic [2*ADDR_SIZE-1:0] req_addr;
  logic [2*ADDR_SIZE-1:0] req_wdata;
  logic [1:0]             done;
  logic [ADDR_SIZE-1:0]   rdata;
  logic                   rsp_err;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  done, rdata, rsp_err
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output done, rdata, rsp_err
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. A lone requester wins outright; when both
// request, the one not granted last wins. The last-grant pointer advances
// only when the owner pulses update, and out of reset it favours requester 0.
//   clk    : clock, rising edge
//   rst    : synchronous, active-high reset
//   req    : request vector, bit i = requester i
//   update : grant is being taken this cycle, record the winner
//   grant  : one-hot grant (zero when nobody requests)
//   idx    : index of the winning requester
//   last   : index of the requester granted most recently
// ---------------------------------------------------------------------------
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       idx,
  output logic       last
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    idx   = 1'b0;
    grant = 2'b00;
    case (req)
      2'b01: idx = 1'b0;
      2'b10: idx = 1'b1;
      2'b11: idx = ~last;
      default: idx = 1'b0;
    endcase
    if (|req) grant = onehot2(idx);
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) begin
      last <= 1'b1;  // pretend requester 1 went last so requester 0 wins first
    end else if (update) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares the single-port RAM command interface between two requesters.
// Each granted transaction is sent to the RAM as two command beats
// ({opcode, payload}); reads then wait for the RAM response, capture it and
// report completion with a one-cycle, one-hot done pulse. Every output comes
// straight from a flop.
//   clk          : clock, rising edge
//   rst          : synchronous, active-high reset
//   bus          : requester bus (ram_port_arbiter_if.slave)
//   busy         : high whenever the FSM is not idle
//   ram_din      : RAM command word {opcode[1:0], payload}
//   ram_rx_valid : RAM command strobe
//   ram_dout     : RAM read data
//   ram_tx_valid : RAM read data valid
// Build option RAM_ARB_RD_TIMEOUT_EN: bounds the read-response wait to
// TIMEOUT_CYCLES cycles; on expiry the transaction completes with rsp_err set
// and rdata left unchanged. Without it the wait is unbounded and rsp_err is 0.
// ---------------------------------------------------------------------------
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
`ifdef RAM_ARB_RD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    bus,
  output logic                 busy,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  state_t               state;
  logic                 idx_q;
  logic                 we_q;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [ADDR_SIZE-1:0] rdata_q;
  logic [1:0]           done_q;

  logic [1:0]           grant;
  logic                 win_idx;
  logic                 win_we;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [ADDR_SIZE-1:0] win_wdata;
  logic                 arb_update;
  logic                 rr_last_unused;

  // The pointer only moves when a grant is actually taken in IDLE.
  assign arb_update = (state == ST_IDLE) && (|bus.req);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .update (arb_update),
    .grant  (grant),
    .idx    (win_idx),
    .last   (rr_last_unused)
  );

  assign win_we    = bus.req_we[win_idx];
  assign win_addr  = win_idx ? bus.req_addr[2*ADDR_SIZE-1 -: ADDR_SIZE]
                             : bus.req_addr[ADDR_SIZE-1:0];
  assign win_wdata = win_idx ? bus.req_wdata[2*ADDR_SIZE-1 -: ADDR_SIZE]
                             : bus.req_wdata[ADDR_SIZE-1:0];

  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

`ifdef RAM_ARB_RD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      done_q       <= 2'b00;
      busy         <= 1'b0;
      ram_rx_valid <= 1'b0;
      ram_din      <= '0;
`ifdef RAM_ARB_RD_TIMEOUT_EN
      wait_cnt     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      done_q <= 2'b00;  // done is a single-cycle pulse
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            // Everything the transaction needs is captured here, so the
            // requester's inputs may change freely afterwards. The address
            // lives on only inside the registered first command beat.
            idx_q        <= win_idx;
            we_q         <= win_we;
            wdata_q      <= win_we ? win_wdata : '0;  // read data beat carries 0
            ram_rx_valid <= 1'b1;
            ram_din      <= {addr_opcode(win_we), win_addr};
            busy         <= 1'b1;
            state        <= ST_CMD_ADDR;
          end
        end

        ST_CMD_ADDR: begin
          ram_din <= {data_opcode(we_q), wdata_q};
          state   <= ST_CMD_DATA;
        end

        ST_CMD_DATA: begin
          ram_rx_valid <= 1'b0;
          ram_din      <= '0;
          if (we_q) begin
            done_q <= onehot2(idx_q);
`ifdef RAM_ARB_RD_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            state  <= ST_DONE;
          end else begin
`ifdef RAM_ARB_RD_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (ram_tx_valid) begin
            rdata_q <= ram_dout;
            done_q  <= onehot2(idx_q);
`ifdef RAM_ARB_RD_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state   <= ST_DONE;
          end
`ifdef RAM_ARB_RD_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Give up: complete with the error flag, rdata untouched.
            done_q <= onehot2(idx_q);
            err_q  <= 1'b1;
            state  <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          // req is deliberately ignored here; the requester drops it on the
          // edge that ends this cycle.
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy         <= 1'b0;
          ram_rx_valid <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter. A behavioural RAM answers the
// command protocol; a reference model predicts grant order, RAM command words,
// completion cycles and read data, and a monitor compares DUT activity with
// the predicted queues.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int AW  = 8;
  localparam int TMO = 15;

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         scramble;
  } txn_t;

  typedef struct {
    int         idx;
    logic [7:0] rdata;
    bit         err;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [9:0] din;
    int         cyc;
  } cmd_t;

  logic          clk;
  logic          rst;
  logic          busy;
  logic [AW+1:0] ram_din;
  logic          ram_rx_valid;
  logic [AW-1:0] ram_dout;
  logic          ram_tx_valid;

  ram_port_arbiter_if #(.ADDR_SIZE(AW)) bus ();

  ram_port_arbiter #(.ADDR_SIZE(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return 8'(((i * 37) + 5) ^ 'h5A);
  endfunction

  // Behavioural RAM. It shares the system reset, so commands presented while
  // rst is high are ignored.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_a;
  bit         ram_filled = 1'b0;
  bit         ram_stuck  = 1'b0;

  always @(posedge clk) begin
    if (!ram_filled) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
      ram_filled <= 1'b1;
    end
    if (rst) begin
      ram_tx_valid <= 1'b0;
    end else if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: begin ram_a <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
        2'b01: begin ram_mem[ram_a] <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
        2'b10: begin ram_a <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
        default: begin ram_dout <= ram_mem[ram_a]; ram_tx_valid <= !ram_stuck; end
      endcase
    end
  end

  // Reference model state.
  bit         m_last;   // 1: requester 1 was granted most recently
  logic [7:0] m_mem [256];
  logic [7:0] m_rdata;
  bit         m_stuck;
  exp_t       sb_q[$];
  cmd_t       cmd_q[$];
  txn_t       q0[$];
  txn_t       q1[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic txn_t mk(input bit we, input logic [7:0] a, input logic [7:0] d,
                              input bit s);
    txn_t x;
    x.we = we; x.addr = a; x.wdata = d; x.scramble = s;
    return x;
  endfunction

  // Predict one transaction granted in cycle t; returns its done cycle.
  task automatic model_one(input int w, input txn_t x, input int t, output int d);
    exp_t e;
    cmd_t c;
    c.din = {(x.we ? 2'b00 : 2'b10), x.addr};
    c.cyc = t + 1;
    cmd_q.push_back(c);
    c.din = x.we ? {2'b01, x.wdata} : {2'b11, 8'h00};
    c.cyc = t + 2;
    cmd_q.push_back(c);
    e.idx = w;
    e.err = 1'b0;
    if (x.we) begin
      m_mem[x.addr] = x.wdata;
      d = t + 3;
    end else if (m_stuck) begin
      e.err = 1'b1;
      d = t + 3 + TMO;
    end else begin
      m_rdata = m_mem[x.addr];
      d = t + 4;
    end
    e.rdata = m_rdata;
    e.cyc   = d;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int i, input txn_t x);
    bus.req[i]                 = 1'b1;
    bus.req_we[i]              = x.we;
    bus.req_addr[i*AW +: AW]   = x.addr;
    bus.req_wdata[i*AW +: AW]  = x.wdata;
  endtask

  task automatic perturb(input int i);
    bus.req_we[i]              = ~bus.req_we[i];
    bus.req_addr[i*AW +: AW]   = 8'($urandom);
    bus.req_wdata[i*AW +: AW]  = 8'($urandom);
  endtask

  // Runs everything queued in q0/q1. A requester with more work keeps req high
  // and loads its next transaction on the edge that ends its done cycle.
  task automatic run_batch();
    txn_t       a[$];
    txn_t       b[$];
    txn_t       x;
    int         t, d, w, guard;
    bit         act0, act1, scr0, scr1;
    logic [1:0] seen;
    a = q0; b = q1; t = cyc;
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) w = m_last ? 0 : 1;
      else w = (a.size() > 0) ? 0 : 1;
      if (w == 0) x = a.pop_front(); else x = b.pop_front();
      m_last = (w == 1);
      model_one(w, x, t, d);
      t = d + 1;
    end
    act0 = 0; act1 = 0; scr0 = 0; scr1 = 0;
    if (q0.size() > 0) begin x = q0.pop_front(); drive(0, x); act0 = 1; scr0 = x.scramble; end
    if (q1.size() > 0) begin x = q1.pop_front(); drive(1, x); act1 = 1; scr1 = x.scramble; end
    guard = 0;
    while ((act0 || act1) && guard < 600) begin
      @(negedge clk);
      seen = bus.done;
      tick();
      guard++;
      if (scr0) begin perturb(0); scr0 = 0; end
      if (scr1) begin perturb(1); scr1 = 0; end
      if (act0 && seen[0]) begin
        if (q0.size() > 0) begin x = q0.pop_front(); drive(0, x); scr0 = x.scramble; end
        else begin bus.req[0] = 1'b0; perturb(0); act0 = 0; end
      end
      if (act1 && seen[1]) begin
        if (q1.size() > 0) begin x = q1.pop_front(); drive(1, x); scr1 = x.scramble; end
        else begin bus.req[1] = 1'b0; perturb(1); act1 = 0; end
      end
    end
    check("batch_completed", {30'd0, act1, act0}, 32'd0);
    bus.req = 2'b00;
  endtask

  task automatic monitor();
    exp_t e;
    cmd_t c;
    forever begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {30'd0, bus.done}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("done_onehot", {30'd0, bus.done}, (e.idx == 1) ? 32'd2 : 32'd1);
          check("done_cycle", cyc, e.cyc);
          check("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
          check("busy_in_done", {31'd0, busy}, 32'd1);
        end
      end
      if (ram_rx_valid) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", {22'd0, ram_din}, 32'h3ff);
        end else begin
          c = cmd_q.pop_front();
          check("ram_din", {22'd0, ram_din}, {22'd0, c.din});
          check("cmd_cycle", cyc, c.cyc);
        end
      end
    end
  endtask

  int         n0, n1, t0;
  logic [7:0] old_val;

  initial begin
    fork
      monitor();
    join_none

    rst           = 1'b1;
    bus.req       = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    m_last  = 1'b1;
    m_rdata = 8'h00;
    m_stuck = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {30'd0, bus.done}, 32'd0);
    check("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_valid", {31'd0, ram_rx_valid}, 32'd0);
    check("rst_ram_din", {22'd0, ram_din}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Requester 0 writes 0xA5 to 0x12, then requester 1 reads it back.
    q0.push_back(mk(1'b1, 8'h12, 8'hA5, 1'b0));
    run_batch();
    q1.push_back(mk(1'b0, 8'h12, 8'h00, 1'b0));
    run_batch();

    // Both requesters held: 0 writes, 1 reads; grants must alternate from 0.
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk(1'b1, 8'($urandom_range(0, 7)), 8'($urandom), 1'b0));
      q1.push_back(mk(1'b0, 8'($urandom_range(0, 7)), 8'h00, 1'b0));
    end
    run_batch();

    // Inputs disturbed right after the grant must not reach the RAM.
    q0.push_back(mk(1'b1, 8'h40, 8'h3C, 1'b1));
    run_batch();
    q1.push_back(mk(1'b0, 8'h40, 8'h00, 1'b1));
    run_batch();

    // Reset during the data beat of a write: nothing completes, RAM unchanged.
    tick();
    t0 = cyc;
    old_val = m_mem[8'h20];
    drive(0, mk(1'b1, 8'h20, ~old_val, 1'b0));
    cmd_q.push_back('{din: {2'b00, 8'h20}, cyc: t0 + 1});
    cmd_q.push_back('{din: {2'b01, ~old_val}, cyc: t0 + 2});
    tick();
    tick();
    rst = 1'b1;
    bus.req = 2'b00;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rx_valid", {31'd0, ram_rx_valid}, 32'd0);
    check("abort_done", {30'd0, bus.done}, 32'd0);
    check("abort_rdata", {24'd0, bus.rdata}, 32'd0);
    m_last  = 1'b1;
    m_rdata = 8'h00;
    tick();
    tick();
    q1.push_back(mk(1'b0, 8'h20, 8'h00, 1'b0));
    run_batch();

    // Random traffic over a small address window to hit read-after-write.
    repeat (25) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      for (int k = 0; k < n0; k++)
        q0.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), 1'b0));
      for (int k = 0; k < n1; k++)
        q1.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), 1'b0));
      repeat ($urandom_range(0, 2)) tick();
      run_batch();
    end

`ifdef RAM_ARB_RD_TIMEOUT_EN
    // RAM never answers: completion after the wait limit with the error flag.
    m_stuck   = 1'b1;
    ram_stuck = 1'b1;
    q1.push_back(mk(1'b0, 8'h03, 8'h00, 1'b0));
    run_batch();
    m_stuck   = 1'b0;
    ram_stuck = 1'b0;
    q0.push_back(mk(1'b0, 8'h03, 8'h00, 1'b0));
    run_batch();
`endif

    repeat (6) tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);
    check("cmd_queue_drained", cmd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
